// File: rtl/qpu_exu_oitf_pkg.sv
// -----------------------------------------------------------------------------
// qpu_exu_oitf_pkg
// Shared widths and sizing for the QPU execute-unit outstanding instruction
// track FIFO (OITF). These stand in for the QPU_defines.v macros.
//   QPU_RFIDX_REAL_WIDTH : register-file index width
//   QPU_QUBIT_NUM        : width of the qubit mask
//   QPU_OITF_DEPTH       : number of OITF entries
//   QPU_OITF_PTR_W       : entry pointer width (log2 of depth)
//   QPU_OITF_MEAS_MAX    : maximum outstanding measure entries
// -----------------------------------------------------------------------------
package qpu_exu_oitf_pkg;

    localparam int QPU_RFIDX_REAL_WIDTH = 5;
    localparam int QPU_QUBIT_NUM        = 8;
    localparam int QPU_OITF_DEPTH       = 4;
    localparam int QPU_OITF_PTR_W       = 2;
    localparam int QPU_OITF_MEAS_MAX    = 2;

    // Payload of one OITF slot (valid is kept separately).
    typedef struct packed {
        logic                            rdwen;
        logic [QPU_RFIDX_REAL_WIDTH-1:0] rdidx;
        logic                            measure;
        logic [QPU_QUBIT_NUM-1:0]        qubitlist;
    } oitf_entry_t;

endpackage

// File: rtl/qpu_oitf_entry.sv
// -----------------------------------------------------------------------------
// qpu_oitf_entry
// One OITF storage slot. Loads its fields and sets valid on set_i, clears
// valid on clr_i, and computes its own hazard match bits against the
// instruction currently being dispatched.
//   clk, rst_n            : clock, synchronous active-low reset
//   set_i / clr_i         : allocate into / retire from this slot
//   rdwen_i..qubitlist_i  : fields written on allocation
//   disp_*_i              : operand enables/indices of the dispatching instr
//   valid_o..qubitlist_o  : stored state
//   match_*_o             : per-slot rs1/rs2/rd/qubit hazard bits
// -----------------------------------------------------------------------------
module qpu_oitf_entry
    import qpu_exu_oitf_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            set_i,
    input  logic                            clr_i,
    input  logic                            rdwen_i,
    input  logic [QPU_RFIDX_REAL_WIDTH-1:0] rdidx_i,
    input  logic                            measure_i,
    input  logic [QPU_QUBIT_NUM-1:0]        qubitlist_i,
    input  logic                            disp_rs1en_i,
    input  logic [QPU_RFIDX_REAL_WIDTH-1:0] disp_rs1idx_i,
    input  logic                            disp_rs2en_i,
    input  logic [QPU_RFIDX_REAL_WIDTH-1:0] disp_rs2idx_i,
    input  logic                            disp_rdwen_i,
    input  logic [QPU_RFIDX_REAL_WIDTH-1:0] disp_rdidx_i,
    input  logic                            disp_qfren_i,
    input  logic [QPU_QUBIT_NUM-1:0]        disp_qubitlist_i,
    output logic                            valid_o,
    output logic                            rdwen_o,
    output logic [QPU_RFIDX_REAL_WIDTH-1:0] rdidx_o,
    output logic                            measure_o,
    output logic [QPU_QUBIT_NUM-1:0]        qubitlist_o,
    output logic                            match_rs1_o,
    output logic                            match_rs2_o,
    output logic                            match_rd_o,
    output logic                            match_qf_o
);

    logic        valid_q;
    oitf_entry_t ent_q;

    // Set and clear never target the same slot in one cycle: that would need
    // a full FIFO accepting an allocation, which the readies forbid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ent_q   <= '0;
        end else if (set_i) begin
            valid_q <= 1'b1;
            ent_q   <= '{rdwen: rdwen_i, rdidx: rdidx_i,
                         measure: measure_i, qubitlist: qubitlist_i};
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o     = valid_q;
    assign rdwen_o     = ent_q.rdwen;
    assign rdidx_o     = ent_q.rdidx;
    assign measure_o   = ent_q.measure;
    assign qubitlist_o = ent_q.qubitlist;

    assign match_rs1_o = valid_q & disp_rs1en_i & ent_q.rdwen & (ent_q.rdidx == disp_rs1idx_i);
    assign match_rs2_o = valid_q & disp_rs2en_i & ent_q.rdwen & (ent_q.rdidx == disp_rs2idx_i);
    assign match_rd_o  = valid_q & disp_rdwen_i & ent_q.rdwen & (ent_q.rdidx == disp_rdidx_i);
    // Qubit hazards only matter against outstanding measurements.
    assign match_qf_o  = valid_q & disp_qfren_i & ent_q.measure
                       & (|(ent_q.qubitlist & disp_qubitlist_i));

endmodule

// File: rtl/qpu_exu_oitf.sv
// -----------------------------------------------------------------------------
// qpu_exu_oitf
// Outstanding Instruction Track FIFO for the QPU execute unit. Dispatch
// allocates one entry per long-pipe instruction (including measure/FMR);
// entries retire in order on long-pipe writeback. Every cycle the block
// reports register and qubit-list hazards of the dispatching instruction
// against the outstanding entries.
//   disp_oitf_ena/ready     : allocate request / not full
//   disp_moitf_ena/ready    : measure allocation / measure slot available
//   disp_oitf_* operands    : enables, indices and qubit mask for matching
//   oitfrd_match_*, oitfqf_match_dispql : hazard outputs
//   dis_ptr / ret_ptr       : next-allocation / oldest entry index
//   oitf_ret_ena            : retire oldest entry
//   ret_*                   : fields of the oldest entry
//   oitf_empty              : no outstanding entries
// -----------------------------------------------------------------------------
module qpu_exu_oitf
    import qpu_exu_oitf_pkg::*;
#(
    parameter int DEPTH    = QPU_OITF_DEPTH,
    parameter int MEAS_MAX = QPU_OITF_MEAS_MAX,
    parameter int PTR_W    = $clog2(DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            disp_oitf_ena,
    output logic                            disp_oitf_ready,
    input  logic                            disp_moitf_ena,
    output logic                            disp_moitf_ready,
    input  logic                            disp_oitf_rs1en,
    input  logic                            disp_oitf_rs2en,
    input  logic                            disp_oitf_rdwen,
    input  logic                            disp_oitf_qfren,
    input  logic [QPU_RFIDX_REAL_WIDTH-1:0] disp_oitf_rs1idx,
    input  logic [QPU_RFIDX_REAL_WIDTH-1:0] disp_oitf_rs2idx,
    input  logic [QPU_RFIDX_REAL_WIDTH-1:0] disp_oitf_rdidx,
    input  logic [QPU_QUBIT_NUM-1:0]        disp_oitf_qubitlist,
    output logic                            oitfrd_match_disprs1,
    output logic                            oitfrd_match_disprs2,
    output logic                            oitfrd_match_disprd,
    output logic                            oitfqf_match_dispql,
    output logic [PTR_W-1:0]                dis_ptr,
    input  logic                            oitf_ret_ena,
    output logic [PTR_W-1:0]                ret_ptr,
    output logic                            ret_rdwen,
    output logic                            ret_measure,
    output logic [QPU_RFIDX_REAL_WIDTH-1:0] ret_rdidx,
    output logic [QPU_QUBIT_NUM-1:0]        ret_qubitlist,
    output logic                            oitf_empty
);

    // Pointers carry one extra MSB as the wrap flag.
    logic [PTR_W:0] alloc_ptr_q, alloc_ptr_d;
    logic [PTR_W:0] ret_ptr_q,   ret_ptr_d;
    logic [PTR_W:0] meas_cnt_q,  meas_cnt_d;

    logic full;
    logic alloc_ok;
    logic ret_ok;

    logic [DEPTH-1:0]                valid_v;
    logic [DEPTH-1:0]                rdwen_v;
    logic [DEPTH-1:0]                meas_v;
    logic [QPU_RFIDX_REAL_WIDTH-1:0] rdidx_v [DEPTH];
    logic [QPU_QUBIT_NUM-1:0]        ql_v    [DEPTH];
    logic [DEPTH-1:0]                m_rs1_v;
    logic [DEPTH-1:0]                m_rs2_v;
    logic [DEPTH-1:0]                m_rd_v;
    logic [DEPTH-1:0]                m_qf_v;

    assign full = (alloc_ptr_q[PTR_W-1:0] == ret_ptr_q[PTR_W-1:0])
                & (alloc_ptr_q[PTR_W] != ret_ptr_q[PTR_W]);
    assign oitf_empty = (alloc_ptr_q == ret_ptr_q);

    // Readies depend on registered state only, so a same-cycle retire never
    // opens room for an allocation.
    assign disp_oitf_ready  = ~full;
    assign disp_moitf_ready = ~full & (int'(meas_cnt_q) < MEAS_MAX);

    // A measure allocation additionally needs a free measure slot.
    assign alloc_ok = disp_oitf_ena & disp_oitf_ready & (~disp_moitf_ena | disp_moitf_ready);
    assign ret_ok   = oitf_ret_ena & ~oitf_empty;

    assign dis_ptr       = alloc_ptr_q[PTR_W-1:0];
    assign ret_ptr       = ret_ptr_q[PTR_W-1:0];
    assign ret_rdwen     = rdwen_v[ret_ptr];
    assign ret_measure   = meas_v[ret_ptr];
    assign ret_rdidx     = rdidx_v[ret_ptr];
    assign ret_qubitlist = ql_v[ret_ptr];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic [PTR_W-1:0] IDX = PTR_W'(gi);

            qpu_oitf_entry u_entry (
                .clk             (clk),
                .rst_n           (rst_n),
                .set_i           (alloc_ok & (dis_ptr == IDX)),
                .clr_i           (ret_ok & (ret_ptr == IDX)),
                .rdwen_i         (disp_oitf_rdwen),
                .rdidx_i         (disp_oitf_rdidx),
                .measure_i       (disp_moitf_ena),
                .qubitlist_i     (disp_oitf_qubitlist),
                .disp_rs1en_i    (disp_oitf_rs1en),
                .disp_rs1idx_i   (disp_oitf_rs1idx),
                .disp_rs2en_i    (disp_oitf_rs2en),
                .disp_rs2idx_i   (disp_oitf_rs2idx),
                .disp_rdwen_i    (disp_oitf_rdwen),
                .disp_rdidx_i    (disp_oitf_rdidx),
                .disp_qfren_i    (disp_oitf_qfren),
                .disp_qubitlist_i(disp_oitf_qubitlist),
                .valid_o         (valid_v[gi]),
                .rdwen_o         (rdwen_v[gi]),
                .rdidx_o         (rdidx_v[gi]),
                .measure_o       (meas_v[gi]),
                .qubitlist_o     (ql_v[gi]),
                .match_rs1_o     (m_rs1_v[gi]),
                .match_rs2_o     (m_rs2_v[gi]),
                .match_rd_o      (m_rd_v[gi]),
                .match_qf_o      (m_qf_v[gi])
            );
        end
    endgenerate

    assign oitfrd_match_disprs1 = |m_rs1_v;
    assign oitfrd_match_disprs2 = |m_rs2_v;
    assign oitfrd_match_disprd  = |m_rd_v;
    assign oitfqf_match_dispql  = |m_qf_v;

    always_comb begin
        alloc_ptr_d = alloc_ptr_q;
        ret_ptr_d   = ret_ptr_q;
        meas_cnt_d  = meas_cnt_q;
        if (alloc_ok) begin
            alloc_ptr_d = alloc_ptr_q + (PTR_W+1)'(1);
        end
        if (ret_ok) begin
            ret_ptr_d = ret_ptr_q + (PTR_W+1)'(1);
        end
        // Net the measure count when a measure allocates and retires together.
        if (alloc_ok & disp_moitf_ena) begin
            meas_cnt_d = meas_cnt_d + (PTR_W+1)'(1);
        end
        if (ret_ok & ret_measure) begin
            meas_cnt_d = meas_cnt_d - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alloc_ptr_q <= '0;
            ret_ptr_q   <= '0;
            meas_cnt_q  <= '0;
        end else begin
            alloc_ptr_q <= alloc_ptr_d;
            ret_ptr_q   <= ret_ptr_d;
            meas_cnt_q  <= meas_cnt_d;
        end
    end

    // valid_v is tracked per slot; the pointers already determine occupancy.
    logic unused_valid;
    assign unused_valid = |valid_v;

endmodule

// File: tb/tb_qpu_exu_oitf.sv
module tb_qpu_exu_oitf;
    import qpu_exu_oitf_pkg::*;

    localparam int DEPTH = 4;
    localparam int MMAX  = 2;
    localparam int RF    = QPU_RFIDX_REAL_WIDTH;
    localparam int QN    = QPU_QUBIT_NUM;

    logic clk = 1'b0;
    logic rst_n;
    logic disp_oitf_ena, disp_oitf_ready, disp_moitf_ena, disp_moitf_ready;
    logic disp_oitf_rs1en, disp_oitf_rs2en, disp_oitf_rdwen, disp_oitf_qfren;
    logic [RF-1:0] disp_oitf_rs1idx, disp_oitf_rs2idx, disp_oitf_rdidx;
    logic [QN-1:0] disp_oitf_qubitlist;
    logic oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd, oitfqf_match_dispql;
    logic [1:0] dis_ptr, ret_ptr;
    logic oitf_ret_ena, ret_rdwen, ret_measure, oitf_empty;
    logic [RF-1:0] ret_rdidx;
    logic [QN-1:0] ret_qubitlist;

    always #5 clk = ~clk;

    qpu_exu_oitf #(.DEPTH(DEPTH), .MEAS_MAX(MMAX), .PTR_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_oitf_ena(disp_oitf_ena), .disp_oitf_ready(disp_oitf_ready),
        .disp_moitf_ena(disp_moitf_ena), .disp_moitf_ready(disp_moitf_ready),
        .disp_oitf_rs1en(disp_oitf_rs1en), .disp_oitf_rs2en(disp_oitf_rs2en),
        .disp_oitf_rdwen(disp_oitf_rdwen), .disp_oitf_qfren(disp_oitf_qfren),
        .disp_oitf_rs1idx(disp_oitf_rs1idx), .disp_oitf_rs2idx(disp_oitf_rs2idx),
        .disp_oitf_rdidx(disp_oitf_rdidx), .disp_oitf_qubitlist(disp_oitf_qubitlist),
        .oitfrd_match_disprs1(oitfrd_match_disprs1), .oitfrd_match_disprs2(oitfrd_match_disprs2),
        .oitfrd_match_disprd(oitfrd_match_disprd), .oitfqf_match_dispql(oitfqf_match_dispql),
        .dis_ptr(dis_ptr), .oitf_ret_ena(oitf_ret_ena), .ret_ptr(ret_ptr),
        .ret_rdwen(ret_rdwen), .ret_measure(ret_measure), .ret_rdidx(ret_rdidx),
        .ret_qubitlist(ret_qubitlist), .oitf_empty(oitf_empty)
    );

    // One cycle of stimulus plus the outputs expected during that cycle.
    // exp = {ready, mready, empty, dis_ptr[1:0], ret_ptr[1:0], rs1, rs2, rd, qf}
    typedef struct {
        logic          rst;
        logic          ae, me, re, rdw;
        logic [RF-1:0] rd;
        logic [QN-1:0] ql;
        logic          s1en;
        logic [RF-1:0] s1;
        logic          s2en;
        logic [RF-1:0] s2;
        logic          qfen;
        logic [10:0]   exp;
    } vec_t;

    typedef struct {
        logic          rdw;
        logic [RF-1:0] rd;
        logic          meas;
        logic [QN-1:0] ql;
    } sb_t;

    int   errors = 0;
    int   checks = 0;
    sb_t  sb[$];
    int   mcnt = 0;
    vec_t tbl[$];

    function automatic vec_t mk(logic ae, logic me, logic re, logic rdw, logic [RF-1:0] rd,
                                logic [QN-1:0] ql, logic s1en, logic [RF-1:0] s1,
                                logic s2en, logic [RF-1:0] s2, logic qfen, logic [10:0] e);
        vec_t r;
        r.rst = 1'b1; r.ae = ae; r.me = me; r.re = re; r.rdw = rdw; r.rd = rd; r.ql = ql;
        r.s1en = s1en; r.s1 = s1; r.s2en = s2en; r.s2 = s2; r.qfen = qfen; r.exp = e;
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string nm);
        logic [10:0] act;
        bit alloc_ok, ret_ok;
        sb_t e;
        @(negedge clk);
        rst_n = v.rst; disp_oitf_ena = v.ae; disp_moitf_ena = v.me; oitf_ret_ena = v.re;
        disp_oitf_rdwen = v.rdw; disp_oitf_rdidx = v.rd; disp_oitf_qubitlist = v.ql;
        disp_oitf_rs1en = v.s1en; disp_oitf_rs1idx = v.s1;
        disp_oitf_rs2en = v.s2en; disp_oitf_rs2idx = v.s2; disp_oitf_qfren = v.qfen;
        #1;
        act = {disp_oitf_ready, disp_moitf_ready, oitf_empty, dis_ptr, ret_ptr,
               oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd, oitfqf_match_dispql};
        check(nm, 32'(act), 32'(v.exp));
        if (!v.rst) begin
            sb.delete();
            mcnt = 0;
        end else begin
            ret_ok   = v.re && (sb.size() > 0);
            alloc_ok = v.ae && (sb.size() < DEPTH) && (!v.me || mcnt < MMAX);
            if (ret_ok) begin
                e = sb.pop_front();
                check({nm, "_ret"}, {17'd0, ret_rdwen, ret_measure, ret_rdidx, ret_qubitlist},
                      {17'd0, e.rdw, e.meas, e.rd, e.ql});
                if (e.meas) mcnt--;
            end
            if (alloc_ok) begin
                e.rdw = v.rdw; e.rd = v.rd; e.meas = v.me; e.ql = v.ql;
                sb.push_back(e);
                if (v.me) mcnt++;
            end
        end
    endtask

    initial begin
        vec_t w;
        rst_n = 1'b0; disp_oitf_ena = 0; disp_moitf_ena = 0; oitf_ret_ena = 0;
        disp_oitf_rs1en = 0; disp_oitf_rs2en = 0; disp_oitf_rdwen = 0; disp_oitf_qfren = 0;
        disp_oitf_rs1idx = '0; disp_oitf_rs2idx = '0; disp_oitf_rdidx = '0; disp_oitf_qubitlist = '0;
        repeat (2) @(negedge clk);

        //              ae me re rdw rd   ql     s1en s1 s2en s2 qf  exp
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 11'b1_1_1_00_00_0000)); // reset state
        tbl.push_back(mk(1, 0, 0, 1, 1, 8'h00, 0, 0, 0, 0, 0, 11'b1_1_1_00_00_0000));
        tbl.push_back(mk(1, 0, 0, 1, 2, 8'h00, 0, 0, 0, 0, 0, 11'b1_1_0_01_00_0000));
        tbl.push_back(mk(1, 0, 0, 1, 3, 8'h00, 0, 0, 0, 0, 0, 11'b1_1_0_10_00_0000));
        tbl.push_back(mk(1, 0, 0, 1, 4, 8'h00, 0, 0, 0, 0, 0, 11'b1_1_0_11_00_0000));
        tbl.push_back(mk(1, 0, 0, 1, 1, 8'h00, 1, 4, 1, 7, 0, 11'b0_0_0_00_00_1010)); // full, 5th ignored
        tbl.push_back(mk(1, 0, 1, 1, 9, 8'h00, 0, 0, 0, 0, 0, 11'b0_0_0_00_00_0000)); // full + retire
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 11'b1_1_0_00_01_0000));
        tbl.push_back(mk(0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 11'b1_1_0_00_01_0000));
        tbl.push_back(mk(0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 11'b1_1_0_00_10_0000));
        tbl.push_back(mk(0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 11'b1_1_0_00_11_0000));
        tbl.push_back(mk(1, 0, 0, 1, 5, 8'h00, 0, 0, 0, 0, 0, 11'b1_1_1_00_00_0000)); // rd=5
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 1, 5, 0, 0, 0, 11'b1_1_0_01_00_1000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 5, 0, 0, 0, 11'b1_1_0_01_00_0000));
        tbl.push_back(mk(0, 0, 1, 0, 0, 8'h00, 1, 5, 0, 0, 0, 11'b1_1_0_01_00_1000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 1, 5, 0, 0, 0, 11'b1_1_1_01_01_0000));
        tbl.push_back(mk(1, 1, 0, 0, 0, 8'h06, 0, 0, 0, 0, 0, 11'b1_1_1_01_01_0000)); // measure 06
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h04, 0, 0, 0, 0, 1, 11'b1_1_0_10_01_0001));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h08, 0, 0, 0, 0, 1, 11'b1_1_0_10_01_0000));
        tbl.push_back(mk(1, 0, 0, 0, 0, 8'h30, 0, 0, 0, 0, 1, 11'b1_1_0_10_01_0000)); // non-measure 30
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h10, 0, 0, 0, 0, 1, 11'b1_1_0_11_01_0000));
        tbl.push_back(mk(1, 1, 0, 0, 0, 8'h01, 0, 0, 0, 0, 0, 11'b1_1_0_11_01_0000)); // 2nd measure
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 11'b1_0_0_00_01_0000));
        tbl.push_back(mk(1, 1, 0, 0, 0, 8'h01, 0, 0, 0, 0, 0, 11'b1_0_0_00_01_0000)); // refused
        tbl.push_back(mk(0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 11'b1_0_0_00_01_0000));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 11'b1_1_0_00_10_0000));
        tbl.push_back(mk(1, 0, 1, 1, 6, 8'h00, 0, 0, 0, 0, 0, 11'b1_1_0_00_10_0000)); // alloc+retire
        tbl.push_back(mk(0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 11'b1_1_0_01_11_0000));
        tbl.push_back(mk(0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 11'b1_1_0_01_00_0000));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

        // Alternating allocate/retire across the pointer wrap.
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0)
                w = mk(1, 0, 0, 1, RF'(10 + i), 8'h00, 0, 0, 0, 0, 0,
                       {3'b111, 2'((1 + i / 2) % 4), 2'((1 + i / 2) % 4), 4'b0000});
            else
                w = mk(0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0,
                       {3'b110, 2'((1 + (i + 1) / 2) % 4), 2'((1 + i / 2) % 4), 4'b0000});
            step(w, $sformatf("wrap%0d", i));
        end
        step(mk(0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, {3'b111, 2'd2, 2'd2, 4'b0000}), "wrap_end");

        // Reset with three entries outstanding and traffic in flight.
        step(mk(1, 0, 0, 1, 1, 8'h00, 0, 0, 0, 0, 0, {3'b111, 2'd2, 2'd2, 4'b0000}), "rst_a1");
        step(mk(1, 1, 0, 1, 2, 8'h0F, 0, 0, 0, 0, 0, {3'b110, 2'd3, 2'd2, 4'b0000}), "rst_a2");
        step(mk(1, 0, 0, 1, 3, 8'h00, 0, 0, 0, 0, 0, {3'b110, 2'd0, 2'd2, 4'b0000}), "rst_a3");
        w = mk(1, 0, 1, 1, 3, 8'h00, 1, 1, 0, 0, 0, {3'b110, 2'd1, 2'd2, 4'b1010});
        w.rst = 1'b0;
        step(w, "rst_cycle");
        step(mk(0, 0, 0, 1, 3, 8'hFF, 1, 1, 1, 2, 1, {3'b111, 2'd0, 2'd0, 4'b0000}), "post_rst");
        check("post_rst_ret", {17'd0, ret_rdwen, ret_measure, ret_rdidx, ret_qubitlist}, 32'd0);

        @(negedge clk);
        disp_oitf_ena = 0; disp_moitf_ena = 0; oitf_ret_ena = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
